// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: state codes, opcodes,
// ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_IMM_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_LUI   = 3'd6;

  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
                      OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core, with instruction and cycle
// counters for CPI reporting.
module mips_multi_cycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] instr_count,
  output logic [31:0] cycle_count
);

  state_t state_reg, state_next;
  ctrl_t  ctrl;

  // funct is decoded by the downstream ALU control, not by this FSM.
  logic funct_unused;
  assign funct_unused = ^funct;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      state_reg   <= state_next;
      cycle_count <= cycle_count + 32'd1;
      if (state_reg == S_FETCH && mem_ready)
        instr_count <= instr_count + 32'd1;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                                state_next = S_EXEC_R;
          OP_LW, OP_SW:                            state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                          state_next = S_BRANCH;
          OP_J:                                    state_next = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_next = S_EXEC_I;
          default:                                 state_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   state_next = S_ALU_WB;
      S_EXEC_I:   state_next = S_IMM_WB;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_reg)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRC_B_IMM_SH2;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = ~is_known_op(opcode);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = imm_alu_op(opcode);
      end
      S_IMM_WB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PC_SRC_ALUOUT;
        ctrl.pc_write  = zero ^ (opcode == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pc_source = PC_SRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ctrl = '0;
    endcase
    // Reset silences the datapath immediately, even mid-access.
    if (reset)
      ctrl = '0;
  end

  assign pc_write   = ctrl.pc_write;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign illegal_op = ctrl.illegal_op;
  assign state      = state_reg;

endmodule

// File: tb/tb_mips_multi_cycle_ctrl.sv
// Self-checking bench for mips_multi_cycle_ctrl: per-instruction state paths,
// control words, stalls, reset behaviour and counters against a reference model.
module tb_mips_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, pc_source;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count, cycle_count;

  mips_multi_cycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctl_t;

  ctl_t act;
  always_comb act = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write,
                     reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                     pc_source, illegal_op};

  int checks = 0;
  int failures = 0;
  int unsigned m_cycles = 0;
  int unsigned m_instr = 0;

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C,
                      6'h0D, 6'h0F, 6'h23, 6'h2B};
  endfunction

  // Expected control word per step, written from the per-step signal table.
  function automatic ctl_t exp_ctl(input int st, input logic [5:0] op,
                                   input logic z, input logic rdy);
    ctl_t c;
    c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 1; c.ir_write = rdy; c.pc_write = rdy; end
      1:  begin c.alu_src_b = 3; c.illegal_op = !legal(op); end
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2; end
      3:  begin c.mem_read = 1; c.i_or_d = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.i_or_d = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin
            c.alu_src_a = 1; c.alu_op = 1; c.pc_source = 1;
            c.pc_write = (op == 6'h05) ? !z : z;
          end
      9:  begin c.pc_source = 2; c.pc_write = 1; end
      10: begin
            c.alu_src_a = 1; c.alu_src_b = 2;
            case (op)
              6'h0A:   c.alu_op = 5;
              6'h0C:   c.alu_op = 3;
              6'h0D:   c.alu_op = 4;
              6'h0F:   c.alu_op = 6;
              default: c.alu_op = 0;
            endcase
          end
      11: c.reg_write = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Runs one instruction from its FETCH; entered and left at posedge+1.
  task automatic run_instr(input logic [5:0] op, input logic z,
                           input int fstall, input int mstall);
    int path[$];
    int st, stalls;
    ctl_t e;
    path = '{0, 1};
    case (op)
      6'h00:                             begin path.push_back(6); path.push_back(7); end
      6'h23:                             begin path.push_back(2); path.push_back(3); path.push_back(4); end
      6'h2B:                             begin path.push_back(2); path.push_back(5); end
      6'h04, 6'h05:                      path.push_back(8);
      6'h02:                             path.push_back(9);
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin path.push_back(10); path.push_back(11); end
      default: ;
    endcase
    foreach (path[i]) begin
      st = path[i];
      stalls = (st == 0) ? fstall : ((st == 3 || st == 5) ? mstall : 0);
      for (int k = 0; k <= stalls; k++) begin
        opcode = op;
        funct = 6'($urandom);
        zero = z;
        mem_ready = (k == stalls);
        @(negedge clk);
        e = exp_ctl(st, op, z, mem_ready);
        checks++;
        if (state !== 4'(st)) begin
          failures++;
          $display("FAIL state op=%h step=%0d got=%0d want=%0d", op, i, state, st);
        end
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL ctrl op=%h state=%0d got=%h want=%h", op, st, act, e);
        end
        checks++;
        if (cycle_count !== m_cycles || instr_count !== m_instr) begin
          failures++;
          $display("FAIL counters op=%h cycles got=%0d want=%0d instr got=%0d want=%0d",
                   op, cycle_count, m_cycles, instr_count, m_instr);
        end
        @(posedge clk); #1;
        m_cycles++;
        if (st == 0 && k == stalls) m_instr++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 4'd0 || act !== '0 || instr_count !== 0 || cycle_count !== 0) begin
        failures++;
        $display("FAIL reset_hold state=%0d ctrl=%h instr=%0d cycles=%0d want all 0",
                 state, act, instr_count, cycle_count);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_cycles = 0;
    m_instr = 0;
  endtask

  task automatic test_rtype();
    run_instr(6'h00, 1'b0, 0, 0);
    checks++;
    if (instr_count !== 1) begin
      failures++;
      $display("FAIL rtype_instr_count got=%0d want=1", instr_count);
    end
  endtask

  task automatic test_lw_stall();
    int unsigned start;
    start = m_cycles;
    run_instr(6'h23, 1'b0, 0, 2);
    checks++;
    if (cycle_count - start !== 7) begin
      failures++;
      $display("FAIL lw_stall_latency got=%0d want=7", cycle_count - start);
    end
  endtask

  task automatic test_branch();
    run_instr(6'h04, 1'b1, 0, 0);
    run_instr(6'h04, 1'b0, 1, 0);
    run_instr(6'h05, 1'b1, 0, 0);
    run_instr(6'h05, 1'b0, 0, 0);
    run_instr(6'h02, 1'b0, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 1'b0, 0, 0);
    run_instr(6'h11, 1'b1, 1, 0);
  endtask

  task automatic test_async_reset();
    opcode = 6'h2B;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 4'd5 || mem_write !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_memwr state=%0d mem_write=%b want 5/1", state, mem_write);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || state !== 4'd0 || act !== '0 ||
        instr_count !== 0 || cycle_count !== 0) begin
      failures++;
      $display("FAIL async_reset mem_write=%b state=%0d ctrl=%h instr=%0d cycles=%0d want 0",
               mem_write, state, act, instr_count, cycle_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    m_cycles = 0;
    m_instr = 0;
  endtask

  task automatic test_back_to_back();
    test_reset();
    for (int i = 0; i < 10; i++) run_instr(6'h00, 1'b0, 0, 0);
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || instr_count !== 10 || cycle_count !== 40) begin
      failures++;
      $display("FAIL back_to_back state=%0d instr=%0d cycles=%0d want 0/10/40",
               state, instr_count, cycle_count);
    end
    test_reset();
  endtask

  task automatic test_random();
    logic [5:0] ops [14];
    logic [5:0] op;
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F,
            6'h23, 6'h2B, 6'h3F, 6'h01, 6'h20};
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 13)];
      run_instr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    #1;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch();
    test_illegal();
    test_async_reset();
    run_instr(6'h2B, 1'b0, 1, 1);
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
